// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI-mode command engine.
// Holds the engine state encoding, frame/response geometry constants and the
// serial CRC7 step used when the engine generates the command CRC itself.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        SEND = 3'd2,
        HUNT = 3'd3,
        RECV = 3'd4,
        TAIL = 3'd5,
        DONE = 3'd6
    } sd_state_e;

    localparam int         FRAME_BITS = 48;
    localparam int         CRC_BITS   = 40;      // frame bits covered by CRC7
    localparam logic [1:0] START_BITS = 2'b01;
    localparam logic       STOP_BIT   = 1'b1;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;
    localparam int         EXTRA_BITS = 32;
    localparam int         TAIL_CLKS  = 8;
    localparam logic [6:0] CRC7_POLY  = 7'h09;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_clk_div.sv
// SDclk generator: toggles sdclk every CLK_DIV clk50 cycles while run is high,
// holds it low otherwise. rise_tick/fall_tick are single-cycle strobes that are
// high in the clk50 cycle whose closing edge makes sdclk rise/fall.
// Ports: clk50, reset (sync, active high), run -> sdclk, rise_tick, fall_tick.
module sd_clk_div #(
    parameter int CLK_DIV = 64
) (
    input  logic clk50,
    input  logic reset,
    input  logic run,
    output logic sdclk,
    output logic rise_tick,
    output logic fall_tick
);

    logic [7:0] div_cnt_r;
    logic       sdclk_r;
    logic       wrap_s;

    assign wrap_s    = run && (div_cnt_r == 8'(CLK_DIV - 1));
    assign rise_tick = wrap_s && !sdclk_r;
    assign fall_tick = wrap_s && sdclk_r;
    assign sdclk     = sdclk_r;

    // Divider counter and SDclk toggle flop; stopping the clock parks it low.
    always_ff @(posedge clk50) begin
        if (reset) begin
            div_cnt_r <= 8'd0;
            sdclk_r   <= 1'b0;
        end else if (!run) begin
            div_cnt_r <= 8'd0;
            sdclk_r   <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= 8'd0;
            sdclk_r   <= ~sdclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command engine. After reset it drives the power-up clock
// train (SDcs=1, SDout=1), then accepts command frames over cmd_valid/cmd_ready,
// shifts the 48-bit frame out MSB first, hunts for R1, optionally collects four
// trailing bytes (R3/R7) and reports them with a one-cycle resp_valid pulse.
// Ports: clk50/reset; cmd_valid, cmd_ready, cmd_index, cmd_arg, cmd_crc,
// cmd_extra; resp_valid, resp_r1, resp_data, resp_timeout; init_done;
// SD pins SDclk, SDcs, SDout, SDin.
// Build option: define CRC7_GEN_EN to compute the frame CRC7 internally
// (cmd_crc ignored); otherwise cmd_crc is sent verbatim.
module sd_spi_cmd_engine
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV      = 64,
    parameter int INIT_CLKS    = 80,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        cmd_extra,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic        init_done,
    output logic        SDclk,
    output logic        SDcs,
    output logic        SDout,
    input  logic        SDin
);

    sd_state_e   state_r, state_nx_s;
    logic        run_s, rise_s, fall_s, hs_s;
    logic [15:0] cnt_r;
    logic [7:0]  byte_cnt_r;
    logic [46:0] sh_r;          // frame bits still to send after sdout_r
    logic [6:0]  rx_r;
    logic [7:0]  rx_byte_s;
    logic [31:0] data_r;
    logic [7:0]  r1_r;
    logic        extra_r, to_r;
    logic        sdcs_r, sdout_r, cmd_ready_r, resp_valid_r, resp_timeout_r, init_done_r;
    logic [7:0]  resp_r1_r;
    logic [31:0] resp_data_r;
`ifdef CRC7_GEN_EN
    logic [6:0]  crc_r, crc_nx_s;
    assign crc_nx_s = crc7_step(crc_r, sdout_r);
`endif

    assign hs_s      = cmd_valid && cmd_ready_r;
    assign rx_byte_s = {rx_r, SDin};

    sd_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk50     (clk50),
        .reset     (reset),
        .run       (run_s),
        .sdclk     (SDclk),
        .rise_tick (rise_s),
        .fall_tick (fall_s)
    );

    // Next-state decode and SDclk run enable.
    always_comb begin
        state_nx_s = state_r;
        run_s      = 1'b0;
        case (state_r)
            INIT: begin
                run_s = 1'b1;
                if (fall_s && cnt_r == 16'(INIT_CLKS - 1)) state_nx_s = IDLE;
                else                                        state_nx_s = INIT;
            end
            IDLE: begin
                if (hs_s) state_nx_s = SEND;
                else      state_nx_s = IDLE;
            end
            SEND: begin
                run_s = 1'b1;
                if (fall_s && cnt_r == 16'(FRAME_BITS - 1)) state_nx_s = HUNT;
                else                                         state_nx_s = SEND;
            end
            HUNT: begin
                run_s = 1'b1;
                if (rise_s && cnt_r == 16'd7) begin
                    if (!rx_byte_s[7]) begin
                        if (extra_r) state_nx_s = RECV;
                        else         state_nx_s = TAIL;
                    end else if (byte_cnt_r == 8'(RESP_TIMEOUT - 1)) begin
                        state_nx_s = TAIL;
                    end else begin
                        state_nx_s = HUNT;
                    end
                end else begin
                    state_nx_s = HUNT;
                end
            end
            RECV: begin
                run_s = 1'b1;
                if (rise_s && cnt_r == 16'(EXTRA_BITS - 1)) state_nx_s = TAIL;
                else                                         state_nx_s = RECV;
            end
            TAIL: begin
                run_s = 1'b1;
                // cnt_r counts tail rising edges; leave after the 8th cycle falls
                if (fall_s && cnt_r == 16'(TAIL_CLKS)) state_nx_s = DONE;
                else                                    state_nx_s = TAIL;
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = INIT;
            end
        endcase
    end

    // State register, shift/receive datapath and registered pin/handshake outputs.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_r        <= INIT;
            cnt_r          <= 16'd0;
            byte_cnt_r     <= 8'd0;
            sh_r           <= 47'd0;
            rx_r           <= 7'd0;
            data_r         <= 32'd0;
            r1_r           <= FILL_BYTE;
            extra_r        <= 1'b0;
            to_r           <= 1'b0;
            sdcs_r         <= 1'b1;
            sdout_r        <= 1'b1;
            cmd_ready_r    <= 1'b0;
            resp_valid_r   <= 1'b0;
            resp_r1_r      <= FILL_BYTE;
            resp_data_r    <= 32'd0;
            resp_timeout_r <= 1'b0;
            init_done_r    <= 1'b0;
`ifdef CRC7_GEN_EN
            crc_r          <= 7'd0;
`endif
        end else begin
            state_r      <= state_nx_s;
            cmd_ready_r  <= (state_nx_s == IDLE);
            resp_valid_r <= (state_nx_s == DONE);
            case (state_r)
                INIT: begin
                    if (fall_s) begin
                        if (state_nx_s == IDLE) begin
                            cnt_r       <= 16'd0;
                            init_done_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                end
                IDLE: begin
                    if (hs_s) begin
                        // First bit goes on the wire now, ahead of the first rising edge.
                        sdout_r        <= START_BITS[1];
`ifdef CRC7_GEN_EN
                        sh_r           <= {START_BITS[0], cmd_index, cmd_arg, 7'h00, STOP_BIT};
                        crc_r          <= 7'd0;
`else
                        sh_r           <= {START_BITS[0], cmd_index, cmd_arg, cmd_crc, STOP_BIT};
`endif
                        sdcs_r         <= 1'b0;
                        cnt_r          <= 16'd0;
                        byte_cnt_r     <= 8'd0;
                        extra_r        <= cmd_extra;
                        to_r           <= 1'b0;
                        resp_timeout_r <= 1'b0;
                    end
                end
                SEND: begin
                    if (fall_s) begin
                        if (state_nx_s == HUNT) begin
                            cnt_r   <= 16'd0;
                            sdout_r <= 1'b1;
`ifdef CRC7_GEN_EN
                        end else if (cnt_r == 16'(CRC_BITS - 1)) begin
                            // Last covered bit done: splice the finished CRC into the frame.
                            cnt_r   <= cnt_r + 16'd1;
                            crc_r   <= crc_nx_s;
                            sdout_r <= crc_nx_s[6];
                            sh_r    <= {crc_nx_s[5:0], STOP_BIT, 40'd0};
`endif
                        end else begin
                            cnt_r   <= cnt_r + 16'd1;
                            sdout_r <= sh_r[46];
                            sh_r    <= {sh_r[45:0], 1'b0};
`ifdef CRC7_GEN_EN
                            if (cnt_r < 16'(CRC_BITS)) crc_r <= crc_nx_s;
`endif
                        end
                    end
                end
                HUNT: begin
                    if (rise_s) begin
                        rx_r <= rx_byte_s[6:0];
                        if (cnt_r == 16'd7) begin
                            cnt_r <= 16'd0;
                            if (!rx_byte_s[7]) begin
                                r1_r <= rx_byte_s;
                            end else if (byte_cnt_r == 8'(RESP_TIMEOUT - 1)) begin
                                r1_r <= FILL_BYTE;
                                to_r <= 1'b1;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + 8'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                end
                RECV: begin
                    if (rise_s) begin
                        data_r <= {data_r[30:0], SDin};
                        if (state_nx_s == TAIL) cnt_r <= 16'd0;
                        else                    cnt_r <= cnt_r + 16'd1;
                    end
                end
                TAIL: begin
                    if (rise_s) cnt_r <= cnt_r + 16'd1;
                    // Publish results so they line up with the resp_valid pulse.
                    if (state_nx_s == DONE) begin
                        resp_r1_r      <= r1_r;
                        resp_data_r    <= (extra_r && !to_r) ? data_r : 32'd0;
                        resp_timeout_r <= to_r;
                    end
                end
                default: begin
                end
            endcase
            if (state_r != TAIL && state_nx_s == TAIL) sdcs_r <= 1'b1;
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign resp_valid   = resp_valid_r;
    assign resp_r1      = resp_r1_r;
    assign resp_data    = resp_data_r;
    assign resp_timeout = resp_timeout_r;
    assign init_done    = init_done_r;
    assign SDcs         = sdcs_r;
    assign SDout        = sdout_r;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Self-checking bench for sd_spi_cmd_engine: an SD-card responder model on the
// pins plus a frame/response reference computed from the command fields.
module tb_sd_spi_cmd_engine;

    localparam int CLK_DIV      = 2;
    localparam int INIT_CLKS    = 80;
    localparam int RESP_TIMEOUT = 16;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [6:0]  cmd_crc = 7'd0;
    logic        cmd_extra = 1'b0;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        init_done;
    logic        SDclk, SDcs, SDout;
    logic        SDin = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic mosi_q[$];
    logic miso_q[$];
    int   rise_cnt   = 0;
    int   tail_rises = 0;
    bit   init_bad   = 1'b0;
    logic sdclk_prev = 1'b0;
    logic sdcs_prev  = 1'b1;

    always #5 clk50 = ~clk50;

    sd_spi_cmd_engine #(
        .CLK_DIV(CLK_DIV), .INIT_CLKS(INIT_CLKS), .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .clk50(clk50), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_extra(cmd_extra),
        .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
        .resp_timeout(resp_timeout), .init_done(init_done),
        .SDclk(SDclk), .SDcs(SDcs), .SDout(SDout), .SDin(SDin)
    );

    // Card model: captures MOSI on SDclk rise, drives MISO on SDclk fall once a full frame arrived.
    always @(negedge clk50) begin
        if (reset) begin
            rise_cnt = 0;
        end else if (SDclk === 1'b1 && sdclk_prev === 1'b0) begin
            rise_cnt++;
            if (SDcs === 1'b0) mosi_q.push_back(SDout);
            if (sdcs_prev === 1'b1) tail_rises++;
        end else if (SDclk === 1'b0 && sdclk_prev === 1'b1) begin
            if (SDcs === 1'b0 && mosi_q.size() >= 48 && miso_q.size() > 0) SDin = miso_q.pop_front();
            else SDin = 1'b1;
        end
        if (!reset && init_done === 1'b0 && (SDcs !== 1'b1 || SDout !== 1'b1)) init_bad = 1'b1;
        sdclk_prev = SDclk;
        sdcs_prev  = SDcs;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7_model(input logic [39:0] msg);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) miso_q.push_back(b[i]);
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 4000) begin
            @(negedge clk50);
            cyc++;
        end
        chk({tag, ".ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 4000) begin
            @(negedge clk50);
            cyc++;
        end
        chk({tag, ".init_done"}, 64'(init_done), 64'd1);
        chk({tag, ".init_rises"}, 64'(rise_cnt), 64'(INIT_CLKS));
        chk({tag, ".init_pins"}, 64'(init_bad), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input logic extra, input int n_fill,
                           input logic [7:0] r1, input logic [31:0] data, input bit poke);
        logic [6:0]  exp_crc;
        logic [47:0] exp_frame, got;
        logic [7:0]  exp_r1;
        logic        exp_to;
        logic [31:0] exp_data;
        int          cyc, pulses, sz;
        bit          seen, ones;
`ifdef CRC7_GEN_EN
        exp_crc = crc7_model({2'b01, idx, arg});
`else
        exp_crc = crc;
`endif
        exp_frame = {2'b01, idx, arg, exp_crc, 1'b1};
        exp_to    = (n_fill >= RESP_TIMEOUT);
        exp_r1    = exp_to ? 8'hFF : r1;
        exp_data  = (extra && !exp_to) ? data : 32'h0;

        wait_ready(tag);
        @(negedge clk50);
        miso_q.delete();
        mosi_q.delete();
        for (int b = 0; b < n_fill; b++) push_byte(8'h80 | 8'($urandom));
        if (!exp_to) begin
            push_byte(r1);
            if (extra) for (int i = 31; i >= 0; i--) miso_q.push_back(data[i]);
        end
        tail_rises = 0;
        cmd_index = idx; cmd_arg = arg; cmd_crc = crc; cmd_extra = extra; cmd_valid = 1'b1;
        @(negedge clk50);
        cmd_valid = 1'b0;
        chk({tag, ".ready_drop"}, 64'(cmd_ready), 64'd0);
        chk({tag, ".cs_low"}, 64'(SDcs), 64'd0);
        chk({tag, ".to_clear"}, 64'(resp_timeout), 64'd0);
        if (poke) begin
            repeat (20) @(negedge clk50);
            cmd_index = ~idx; cmd_arg = ~arg; cmd_valid = 1'b1;
            @(negedge clk50);
            cmd_valid = 1'b0;
        end

        cyc = 0; pulses = 0; seen = 1'b0;
        while (!(seen && cmd_ready === 1'b1) && cyc < 4000) begin
            @(negedge clk50);
            cyc++;
            if (resp_valid === 1'b1) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    chk({tag, ".r1"}, 64'(resp_r1), 64'(exp_r1));
                    chk({tag, ".data"}, 64'(resp_data), 64'(exp_data));
                    chk({tag, ".timeout"}, 64'(resp_timeout), 64'(exp_to));
                    chk({tag, ".tail_clks"}, 64'(tail_rises), 64'd8);
                    chk({tag, ".cs_high"}, 64'(SDcs), 64'd1);
                end
            end
        end
        chk({tag, ".resp_seen"}, 64'(seen), 64'd1);
        chk({tag, ".pulses"}, 64'(pulses), 64'd1);

        got = 48'd0;
        ones = 1'b1;
        for (int i = 0; i < mosi_q.size(); i++) begin
            if (i < 48) got = {got[46:0], mosi_q[i]};
            else if (mosi_q[i] !== 1'b1) ones = 1'b0;
        end
        chk({tag, ".frame"}, 64'(got), 64'(exp_frame));
        chk({tag, ".mosi_fill"}, 64'(ones), 64'd1);

        sz = mosi_q.size();
        repeat (40) @(negedge clk50);
        chk({tag, ".r1_hold"}, 64'(resp_r1), 64'(exp_r1));
        chk({tag, ".quiet"}, 64'(mosi_q.size()), 64'(sz));
        chk({tag, ".idle_clk"}, 64'(SDclk), 64'd0);
    endtask

    initial begin
        logic [47:0] cmd0_frame;
        cmd0_frame = 48'h40_0000_0000_95;

        repeat (3) @(negedge clk50);
        chk("rst.sdclk", 64'(SDclk), 64'd0);
        chk("rst.sdcs", 64'(SDcs), 64'd1);
        chk("rst.sdout", 64'(SDout), 64'd1);
        chk("rst.ready", 64'(cmd_ready), 64'd0);
        chk("rst.valid", 64'(resp_valid), 64'd0);
        chk("rst.r1", 64'(resp_r1), 64'hFF);
        chk("rst.data", 64'(resp_data), 64'd0);
        chk("rst.to", 64'(resp_timeout), 64'd0);
        chk("rst.init", 64'(init_done), 64'd0);
        rise_cnt = 0;
        reset = 1'b0;
        wait_init("pwr");
        @(negedge clk50);
        chk("pwr.ready", 64'(cmd_ready), 64'd1);
        chk("pwr.sdclk", 64'(SDclk), 64'd0);

        // CMD0: the card answers after one fill byte
        run_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 1'b0, 1, 8'h01, 32'h0, 1'b0);
        chk("cmd0.const", 64'({2'b01, 6'd0, 32'h0, 7'h4A, 1'b1}), 64'(cmd0_frame));
        // CMD8 with R7 payload
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h43, 1'b1, 0, 8'h01, 32'h0000_01AA, 1'b0);
        // No answer at all
        run_cmd("tmo", 6'd55, 32'h0, 7'h32, 1'b0, RESP_TIMEOUT, 8'h00, 32'h0, 1'b0);
        // Answer arriving on the very last allowed hunt byte
        run_cmd("late", 6'd17, 32'h1234_5678, 7'h11, 1'b1, RESP_TIMEOUT - 1, 8'h05, 32'hCAFE_F00D, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_cmd($sformatf("rnd%0d", k), 6'($urandom), $urandom, 7'($urandom), 1'($urandom),
                    int'($urandom_range(0, 4)), 8'($urandom) & 8'h7F, $urandom, 1'b0);
        end

        // cmd_valid while busy must be ignored
        run_cmd("busy", 6'd41, 32'h4000_0000, 7'h3B, 1'b1, 2, 8'h00, 32'h80FF_8000, 1'b1);

        // Reset in the middle of a frame
        wait_ready("mid");
        @(negedge clk50);
        cmd_index = 6'd9; cmd_arg = 32'hA5A5_A5A5; cmd_extra = 1'b0; cmd_valid = 1'b1;
        @(negedge clk50);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        chk("mid.sdcs", 64'(SDcs), 64'd1);
        chk("mid.init", 64'(init_done), 64'd0);
        chk("mid.ready", 64'(cmd_ready), 64'd0);
        chk("mid.sdclk", 64'(SDclk), 64'd0);
        rise_cnt = 0;
        init_bad = 1'b0;
        reset = 1'b0;
        wait_init("mid");
        run_cmd("post", 6'd1, 32'h0, 7'h7C, 1'b0, 3, 8'h00, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
